// File: rtl/fetch_queue.sv
// Instruction fetch stage: word-addressed PC generation, one-cycle-latency
// imem reads, and a small {instr, pc} FIFO feeding decode over valid/ready.
//
// state  | meaning
// S_IDLE | out of reset, no requests issued yet
// S_RUN  | fetching; requests issued whenever the queue has room
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc,
  output logic [31:0] o_inst_pc_plus1
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W+2)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_run;

  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_req_pc;
  logic               r_inflight;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W:0]     r_count;
  logic [31:0]        r_instr   [DEPTH];
  logic [31:0]        r_epc     [DEPTH];
  logic [31:0]        r_epc1    [DEPTH];

  logic [PTR_W+1:0]   w_occ;
  logic               w_issue;
  logic               w_write;
  logic               w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_run = 1'b0;
    if (r_state == S_RUN) w_run = 1'b1;
  end

  // Same-cycle pops are deliberately ignored in the room check.
  assign w_occ   = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_inflight};
  assign w_issue = w_run & ~i_redirect & (w_occ < DEPTH_C);
  assign w_write = r_inflight & ~i_redirect;
  assign w_pop   = o_inst_valid & i_inst_ready;

  assign o_imem_req      = w_issue;
  assign o_imem_addr     = r_fetch_pc;
  assign o_inst_valid    = (r_count != '0) & ~i_redirect;
  assign o_inst_data     = r_instr[r_rd_ptr];
  assign o_inst_pc       = r_epc[r_rd_ptr];
  assign o_inst_pc_plus1 = r_epc1[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (i_redirect) begin
      r_fetch_pc <= i_redirect_pc;
      r_inflight <= 1'b0;
      r_rd_ptr   <= r_wr_ptr;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd1;
        r_req_pc   <= r_fetch_pc;
      end
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_write} - {{PTR_W{1'b0}}, w_pop};
    end
  end

  // pc+1 is stored alongside pc so the cleared head reads all-zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_epc[i]   <= '0;
        r_epc1[i]  <= '0;
      end
    end else if (w_write) begin
      r_instr[r_wr_ptr] <= i_imem_rdata;
      r_epc[r_wr_ptr]   <= r_req_pc;
      r_epc1[r_wr_ptr]  <= r_req_pc + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: start-up timing, backpressure, redirects,
// address wrap, random inst_ready with in-order scoreboard, mid-run reset.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus1;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_pc;
  logic [31:0] head;
  logic        found;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_rdata    (imem_rdata),
    .i_redirect      (redirect),
    .i_redirect_pc   (redirect_pc),
    .o_inst_valid    (inst_valid),
    .i_inst_ready    (inst_ready),
    .o_inst_data     (inst_data),
    .o_inst_pc       (inst_pc),
    .o_inst_pc_plus1 (inst_pc_plus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word n holds 32'h1000_0000 + n.
  initial imem_rdata = 32'd0;
  always @(posedge clk) if (imem_req) imem_rdata <= 32'h1000_0000 + imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, settle, then scoreboard the head.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    chk1("no_overflow_write", dut.w_write && (int'(dut.r_count) == 4), 1'b0);
    if (inst_valid) begin
      chk("sb_pc", inst_pc, exp_pc);
      chk("sb_data", inst_data, 32'h1000_0000 + exp_pc);
      chk("sb_pc_plus1", inst_pc_plus1, exp_pc + 32'd1);
      if (rdy) exp_pc = exp_pc + 32'd1;
    end
    if (rd) exp_pc = rpc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk1({tag, "_valid"}, inst_valid, 1'b0);
    chk({tag, "_data"}, inst_data, 32'd0);
    chk({tag, "_pc"}, inst_pc, 32'd0);
    chk({tag, "_pc_plus1"}, inst_pc_plus1, 32'd0);
  endtask

  // Release reset mid-cycle; the next edge is cycle 0.
  task automatic release_and_start();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_pc = 32'd0;
    step(1'b1, 1'b0, 32'd0);
    chk1("c1_req", imem_req, 1'b1);
    chk("c1_addr", imem_addr, 32'd0);
    chk1("c1_valid", inst_valid, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("c2_req", imem_req, 1'b1);
    chk("c2_addr", imem_addr, 32'd1);
    chk1("c2_valid", inst_valid, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("c3_valid", inst_valid, 1'b1);
    chk("c3_data", inst_data, 32'h1000_0000);
    chk("c3_pc", inst_pc, 32'd0);
    chk("c3_pc_plus1", inst_pc_plus1, 32'd1);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_pc      = 32'd0;
    head        = 32'd0;
    found       = 1'b0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    inst_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #3;
    check_reset_outputs("reset");

    release_and_start();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'd0);
      chk1("stream_no_gap", inst_valid, 1'b1);
    end

    // Backpressure: queue must end exactly full and stop requesting.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'd0);
    chk1("bp_req_low", imem_req, 1'b0);
    chk1("bp_valid_held", inst_valid, 1'b1);
    head = exp_pc;
    step(1'b1, 1'b0, 32'd0);
    chk1("bp_release_req_low", imem_req, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("bp_resume_req", imem_req, 1'b1);
    chk("bp_resume_addr", imem_addr, head + 32'd4);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'd0);
      chk1("bp_drain_no_gap", inst_valid, 1'b1);
    end

    // Redirect with count=2, a response pending, and inst_ready=1.
    step(1'b1, 1'b1, 32'h40);
    chk1("rd_valid_low", inst_valid, 1'b0);
    chk1("rd_req_low", imem_req, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("rd1_req", imem_req, 1'b1);
    chk("rd1_addr", imem_addr, 32'h40);
    chk1("rd1_count_zero", inst_valid, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("rd2_valid", inst_valid, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("rd3_valid", inst_valid, 1'b1);
    chk("rd3_pc", inst_pc, 32'h40);
    step(1'b1, 1'b0, 32'd0);
    chk("rd4_pc", inst_pc, 32'h41);

    // Back-to-back redirects: only the second target is fetched.
    step(1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 32'h80);
    chk1("rr_req_low", imem_req, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk("rr_addr", imem_addr, 32'h80);
    chk1("rr1_valid", inst_valid, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("rr2_valid", inst_valid, 1'b0);
    step(1'b1, 1'b0, 32'd0);
    chk1("rr3_valid", inst_valid, 1'b1);
    chk("rr3_pc", inst_pc, 32'h80);

    // Address wrap then random backpressure to wrap FIFO pointers repeatedly.
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFF);
    chk("wrap_pc_plus1", inst_pc_plus1, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("wrap_pc_next", inst_pc, 32'd0);
    for (int i = 0; i < 80; i++) step(1'($urandom_range(0, 1)), 1'b0, 32'd0);

    // Mid-run asynchronous reset while head is at pc 20.
    step(1'b1, 1'b1, 32'd16);
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0, 32'd0);
      if (inst_valid && inst_pc == 32'd20) found = 1'b1;
    end
    chk1("reach_pc20", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    release_and_start();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0);
    chk("restart_stream_pc", inst_pc, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
